// File: rtl/drv_spi_master_pkg.sv
// Shared definitions for the motor-board SPI master: FSM state encodings,
// chip-select indices and internal counter sizing.
package drv_spi_master_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_SCK_HI = 3'd2;
    localparam logic [2:0] ST_SCK_LO = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;

    localparam int unsigned DRV0 = 0;
    localparam int unsigned DRV1 = 1;
    localparam int unsigned DRV2 = 2;
    localparam int unsigned DRV3 = 3;
    localparam int unsigned DRV4 = 4;
    localparam int unsigned ADC0 = 5;
    localparam int unsigned ADC1 = 6;

    // Width of the SETUP/HOLD/GAP dwell counter.
    localparam int unsigned WAIT_W = 8;

    function automatic logic [6:0] cs_onehot_n(input logic [2:0] idx);
        cs_onehot_n = ~(7'd1 << idx);
    endfunction

endpackage

// File: rtl/drv_spi_master_sck_gen.sv
// SCK half-period timer: counts DIV sysclk cycles while run is high and
// strobes phase_end in the last cycle of each half-period.
module spi_sck_gen
    import drv_spi_master_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic sysclk,
    input  logic rst,
    input  logic run,
    output logic phase_end
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          at_term;

    assign at_term   = (cnt == CW'(DIV - 1));
    assign phase_end = run && at_term;

    always_ff @(posedge sysclk) begin
        if (rst || !run) begin
            cnt <= '0;
        end else if (at_term) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/drv_spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0, MSB first) driving the motor-board
// phase-driver chips and ADCs, one word per start strobe.
module drv_spi_master
    import drv_spi_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_CS     = 7,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 2,
    parameter int unsigned CS_GAP     = 4
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            cs_sel,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic [NUM_CS-1:0]     spi_ncs
);

    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

    logic [2:0]            state;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  wait_active;
    logic                  wait_end;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic                  miso_s1;
    logic                  miso_s2;
    logic                  sck_run;
    logic                  phase_end;
    logic                  cs_valid;

    assign sck_run  = (state == ST_SCK_HI) || (state == ST_SCK_LO);
    assign cs_valid = (32'(cs_sel) < NUM_CS);

    spi_sck_gen #(
        .DIV (CLK_DIV)
    ) u_sck_gen (
        .sysclk    (sysclk),
        .rst       (rst),
        .run       (sck_run),
        .phase_end (phase_end)
    );

    always_ff @(posedge sysclk) begin
        if (rst) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= spi_miso;
            miso_s2 <= miso_s1;
        end
    end

    always_comb begin
        wait_active = 1'b0;
        wait_end    = 1'b0;
        case (state)
            ST_SETUP: begin
                wait_active = 1'b1;
                wait_end    = (wait_cnt == WAIT_W'(CS_SETUP - 1));
            end
            ST_HOLD: begin
                wait_active = 1'b1;
                wait_end    = (wait_cnt == WAIT_W'(CS_HOLD - 1));
            end
            ST_GAP: begin
                wait_active = 1'b1;
                wait_end    = (wait_cnt == WAIT_W'(CS_GAP - 1));
            end
            default: begin
                wait_active = 1'b0;
                wait_end    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst || !wait_active || wait_end) begin
            wait_cnt <= '0;
        end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            rx_data  <= '0;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            spi_ncs  <= '1;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bit_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && cs_valid) begin
                        // tx_sh holds only the bits still to be sent after the MSB.
                        tx_sh    <= tx_data << 1;
                        spi_mosi <= tx_data[DATA_WIDTH-1];
                        spi_ncs  <= ~(NUM_CS'(1) << cs_sel);
                        ready    <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (wait_end) begin
                        spi_sck <= 1'b1;
                        state   <= ST_SCK_HI;
                    end
                end
                ST_SCK_HI: begin
                    if (phase_end) begin
                        // Sampling at the end of the high phase absorbs the 2-FF sync delay.
                        rx_sh   <= {rx_sh[DATA_WIDTH-2:0], miso_s2};
                        spi_sck <= 1'b0;
                        if (bit_cnt < BIT_W'(DATA_WIDTH - 1)) begin
                            spi_mosi <= tx_sh[DATA_WIDTH-1];
                            tx_sh    <= tx_sh << 1;
                            state    <= ST_SCK_LO;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_SCK_LO: begin
                    if (phase_end) begin
                        spi_sck <= 1'b1;
                        if (bit_cnt < BIT_W'(DATA_WIDTH - 1)) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        state <= ST_SCK_HI;
                    end
                end
                ST_HOLD: begin
                    if (wait_end) begin
                        spi_ncs  <= '1;
                        spi_mosi <= 1'b0;
                        done     <= 1'b1;
                        rx_data  <= rx_sh;
                        state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (wait_end) begin
                        ready <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drv_spi_master.sv
// Directed bench for drv_spi_master: loopback and scripted-slave frames,
// ignored starts, mid-frame reset and back-to-back timing.
module tb_drv_spi_master;
    import drv_spi_master_pkg::*;

    logic        sysclk;
    logic        rst;
    logic        start;
    logic [2:0]  cs_sel;
    logic [15:0] tx_data;
    logic        ready;
    logic        done;
    logic [15:0] rx_data;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic [6:0]  spi_ncs;

    int n_checks = 0;
    int n_fail   = 0;

    logic        slave_mode = 1'b0;
    logic [15:0] slave_word = 16'h8001;
    logic [1:0]  lb_pipe    = '0;
    logic [15:0] slave_sh   = '0;
    logic        sck_q      = 1'b0;

    drv_spi_master #(
        .DATA_WIDTH (16),
        .NUM_CS     (7),
        .CLK_DIV    (4),
        .CS_SETUP   (2),
        .CS_HOLD    (2),
        .CS_GAP     (4)
    ) dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .start    (start),
        .cs_sel   (cs_sel),
        .tx_data  (tx_data),
        .ready    (ready),
        .done     (done),
        .rx_data  (rx_data),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_ncs  (spi_ncs)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Loopback with a 2-cycle delay, or a mode-0 slave on ADC1 that shifts on SCK fall.
    always @(posedge sysclk) begin
        lb_pipe <= {lb_pipe[0], spi_mosi};
        sck_q   <= spi_sck;
        if (spi_ncs[ADC1])
            slave_sh <= slave_word;
        else if (sck_q && !spi_sck)
            slave_sh <= {slave_sh[14:0], 1'b0};
    end
    assign spi_miso = slave_mode ? slave_sh[15] : lb_pipe[1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where ready is seen high again.
    task automatic frame(input string tag, input logic [2:0] cs, input logic [15:0] tx,
                         input logic [15:0] exp_rx, input logic [6:0] exp_ncs,
                         input int poke_at);
        int n, rises, dones, lat, ncs_bad, high_cnt;
        logic sck_prev;
        n = 0; rises = 0; dones = 0; lat = 0; ncs_bad = 0; high_cnt = 0;
        sck_prev = 1'b0;
        start = 1'b1; cs_sel = cs; tx_data = tx;
        do begin
            @(negedge sysclk);
            n++;
            start = (n == poke_at);
            if (n == poke_at) begin
                cs_sel  = 3'd1;
                tx_data = ~tx;
            end
            if (spi_sck && !sck_prev) rises++;
            sck_prev = spi_sck;
            if (done) begin
                dones++;
                if (lat == 0) lat = n;
            end
            if (n <= 128) begin
                if (spi_ncs !== exp_ncs) ncs_bad++;
            end else if (spi_ncs === 7'h7F) begin
                high_cnt++;
            end else begin
                ncs_bad++;
            end
        end while (!ready && n < 300);
        start = 1'b0;
        check({tag, "_ready_lat"}, n, 133);
        check({tag, "_sck_rises"}, rises, 16);
        check({tag, "_done_lat"}, lat, 129);
        check({tag, "_done_count"}, dones, 1);
        check({tag, "_rx"}, rx_data, exp_rx);
        check({tag, "_ncs_bad"}, ncs_bad, 0);
        check({tag, "_ncs_high"}, high_cnt, 5);
    endtask

    initial begin
        int n, bad_ready, bad_ncs, rises, dones;
        logic sck_prev;
        rst = 1'b1; start = 1'b0; cs_sel = '0; tx_data = '0;
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        @(negedge sysclk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_rx", rx_data, 0);
        check("rst_sck", spi_sck, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_ncs", spi_ncs, 7'h7F);

        frame("loop_a5c3", 3'd0, 16'hA5C3, 16'hA5C3, 7'b1111110, -1);

        slave_mode = 1'b1;
        frame("slave_adc1", 3'd6, 16'h0000, 16'h8001, 7'b0111111, -1);
        slave_mode = 1'b0;

        frame("poke", 3'd2, 16'h3C5A, 16'h3C5A, 7'b1111011, 50);

        // Out-of-range chip select must be ignored entirely.
        start = 1'b1; cs_sel = 3'd7; tx_data = 16'hFFFF;
        bad_ready = 0; bad_ncs = 0; rises = 0; dones = 0; sck_prev = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge sysclk);
            start = 1'b0;
            if (!ready) bad_ready++;
            if (spi_ncs !== 7'h7F) bad_ncs++;
            if (spi_sck && !sck_prev) rises++;
            sck_prev = spi_sck;
            if (done) dones++;
        end
        check("cs7_ready_low", bad_ready, 0);
        check("cs7_ncs", bad_ncs, 0);
        check("cs7_sck", rises, 0);
        check("cs7_done", dones, 0);
        check("cs7_rx_held", rx_data, 16'h3C5A);

        // Reset in the middle of a frame.
        start = 1'b1; cs_sel = 3'd5; tx_data = 16'hAAAA;
        n = 0;
        while (n < 40) begin
            @(negedge sysclk);
            n++;
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge sysclk);
        rst = 1'b0;
        check("midrst_ncs", spi_ncs, 7'h7F);
        check("midrst_sck", spi_sck, 0);
        check("midrst_ready", ready, 1);
        check("midrst_rx", rx_data, 0);
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sysclk);
            if (done) dones++;
        end
        check("midrst_no_done", dones, 0);
        frame("after_rst", 3'd1, 16'h1234, 16'h1234, 7'b1111101, -1);

        frame("b2b_first", 3'd3, 16'hF00F, 16'hF00F, 7'b1110111, -1);
        frame("b2b_second", 3'd4, 16'h0FF0, 16'h0FF0, 7'b1101111, -1);

        repeat (5) @(negedge sysclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
